// File: rtl/top_k_scanner.sv
// top_k_scanner: scans words 0..len-1 of an external synchronous-read RAM
// and keeps the K largest unsigned values, sorted in descending order.
// Optional macro TOPK_INDEX_EN adds top_idx, the RAM address of each entry.
module top_k_scanner #(
    parameter  int N     = 4,
    parameter  int SIZE  = 32,
    parameter  int K     = 2,
    localparam int ADDRW = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDRW:0]     len,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDRW-1:0]   raddr,
    input  logic [N-1:0]       rdata,
    output logic [K*N-1:0]     top_val,
`ifdef TOPK_INDEX_EN
    output logic [K*ADDRW-1:0] top_idx,
`endif
    output logic [K-1:0]       top_vld
);

    localparam logic [ADDRW:0] SIZE_L = (ADDRW+1)'(SIZE);

    typedef enum logic [1:0] {IDLE, READ, LAST, DONE} state_t;

    state_t                  r_state, w_next;
    logic [ADDRW-1:0]        r_cnt;
    logic [ADDRW:0]          r_len;
    logic                    r_dv;
    logic [K-1:0][N-1:0]     r_val, w_nval;
    logic [K-1:0]            r_vld, w_nvld, w_gt, w_ins;
    logic [ADDRW:0]          w_eff_len;
    logic                    w_accept;

    assign w_eff_len = (len > SIZE_L) ? SIZE_L : len;
    assign w_accept  = (r_state == IDLE) && start;
    assign raddr     = rd_en ? r_cnt : '0;
    assign top_val   = r_val;
    assign top_vld   = r_vld;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake/read-strobe decode
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        rd_en  = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = (w_eff_len != '0) ? READ : LAST;
            READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if ({1'b0, r_cnt} == r_len - 1'b1) w_next = LAST;
            end
            LAST: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Per-entry insertion. The list stays sorted with valid entries packed at
    // the top, so gt[] is monotone: the first set bit is the insertion slot
    // and every set bit below it takes its upper neighbour's value.
    for (genvar j = 0; j < K; j++) begin : g_ent
        assign w_gt[j] = !r_vld[j] || (rdata > r_val[j]);
        if (j == 0) begin : g_top
            assign w_ins[j]  = w_gt[j];
            assign w_nval[j] = w_gt[j] ? rdata : r_val[j];
            assign w_nvld[j] = w_gt[j] | r_vld[j];
        end else begin : g_rest
            assign w_ins[j]  = w_gt[j] && !w_gt[j-1];
            assign w_nval[j] = w_ins[j] ? rdata : (w_gt[j] ? r_val[j-1] : r_val[j]);
            assign w_nvld[j] = w_ins[j] ? 1'b1  : (w_gt[j] ? r_vld[j-1] : r_vld[j]);
        end
    end

`ifdef TOPK_INDEX_EN
    logic [K-1:0][ADDRW-1:0] r_idx, w_nidx;
    logic [ADDRW-1:0]        r_daddr;

    assign top_idx = r_idx;

    for (genvar j = 0; j < K; j++) begin : g_idx
        if (j == 0) begin : g_top
            assign w_nidx[j] = w_gt[j] ? r_daddr : r_idx[j];
        end else begin : g_rest
            assign w_nidx[j] = w_ins[j] ? r_daddr : (w_gt[j] ? r_idx[j-1] : r_idx[j]);
        end
    end

    // Address of the word currently on rdata, and ranked index list
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_daddr <= '0;
            r_idx   <= '0;
        end else begin
            r_daddr <= raddr;
            if (w_accept)  r_idx <= '0;
            else if (r_dv) r_idx <= w_nidx;
        end
    end
`endif

    // Scan counter, read-data valid flag and ranked value list
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_len <= '0;
            r_dv  <= 1'b0;
            r_val <= '0;
            r_vld <= '0;
        end else begin
            r_dv <= rd_en;
            if (w_accept) begin
                r_len <= w_eff_len;
                r_cnt <= '0;
                r_val <= '0;
                r_vld <= '0;
            end else begin
                if (rd_en) r_cnt <= r_cnt + 1'b1;
                if (r_dv) begin
                    r_val <= w_nval;
                    r_vld <= w_nvld;
                end
            end
        end
    end

endmodule

// File: tb/tb_top_k_scanner.sv
// Directed bench for top_k_scanner: a K=2 instance and a K=4 instance, each
// with its own behavioural synchronous-read RAM.
module tb_top_k_scanner;
    localparam int N  = 4;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start2, start4;
    logic [AW:0]   len;
    logic          busy2, done2, rd_en2, busy4, done4, rd_en4;
    logic [AW-1:0] raddr2, raddr4;
    logic [N-1:0]  rdata2, rdata4;
    logic [2*N-1:0] val2;
    logic [4*N-1:0] val4;
    logic [1:0]    vld2;
    logic [3:0]    vld4;
`ifdef TOPK_INDEX_EN
    logic [2*AW-1:0] idx2;
    logic [4*AW-1:0] idx4;
`endif

    top_k_scanner #(.N(N), .SIZE(32), .K(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .len(len), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .raddr(raddr2), .rdata(rdata2), .top_val(val2),
`ifdef TOPK_INDEX_EN
        .top_idx(idx2),
`endif
        .top_vld(vld2));

    top_k_scanner #(.N(N), .SIZE(32), .K(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .len(len), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .raddr(raddr4), .rdata(rdata4), .top_val(val4),
`ifdef TOPK_INDEX_EN
        .top_idx(idx4),
`endif
        .top_vld(vld4));

    logic [N-1:0] mem2 [32];
    logic [N-1:0] mem4 [32];
    always @(posedge clk) if (rd_en2) rdata2 <= mem2[raddr2];
    always @(posedge clk) if (rd_en4) rdata4 <= mem4[raddr4];

    int nvec = 0, nerr = 0, cyc = 0;
    int g_done_cyc, g_ndone, g_nrd, g_aerr, g_maxa;
    logic g_bz_done, g_bz_rst, g_bz_after;
    logic [3:0] g_vld_rst;

    task automatic tick();
        @(posedge clk); #1; cyc++;
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 32; i++) begin mem2[i] = '0; mem4[i] = '0; end
    endtask

    // Start a scan at cycle 0 and observe cycles 1..maxc. xs: cycle to pulse an
    // extra start (len=2); rc: cycle in which reset is held low; sd: pulse start
    // during the done cycle.
    task automatic scan(input bit k4, input int l, input int xs, input int rc,
                        input bit sd, input int maxc);
        logic rd, dn, bz;
        logic [AW-1:0] a;
        g_done_cyc = -1; g_ndone = 0; g_nrd = 0; g_aerr = 0; g_maxa = 0;
        g_bz_done = 1'b1; g_bz_rst = 1'b1; g_bz_after = 1'b1; g_vld_rst = 4'hF;
        len = l[AW:0];
        if (k4) start4 = 1'b1; else start2 = 1'b1;
        cyc = 0;
        tick();
        start2 = 1'b0; start4 = 1'b0;
        while (cyc <= maxc) begin
            rd = k4 ? rd_en4 : rd_en2;
            dn = k4 ? done4  : done2;
            bz = k4 ? busy4  : busy2;
            a  = k4 ? raddr4 : raddr2;
            if (rd) begin
                if (int'(a) != g_nrd) g_aerr++;
                if (int'(a) > g_maxa) g_maxa = int'(a);
                g_nrd++;
            end
            if (g_done_cyc > 0 && cyc == g_done_cyc + 1) g_bz_after = bz;
            if (dn) begin
                g_ndone++;
                if (g_done_cyc < 0) begin g_done_cyc = cyc; g_bz_done = bz; end
            end
            if (cyc == rc + 1) begin
                g_bz_rst  = bz;
                g_vld_rst = k4 ? vld4 : {2'b00, vld2};
            end
            reset = (cyc == rc) ? 1'b0 : 1'b1;
            if (cyc == xs || (sd && dn)) begin
                len = 6'd2;
                if (k4) start4 = 1'b1; else start2 = 1'b1;
            end else begin
                start2 = 1'b0; start4 = 1'b0;
            end
            tick();
        end
        start2 = 1'b0; start4 = 1'b0; reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start2 = 1'b0; start4 = 1'b0; len = '0;
        tick(); tick();
        nvec++; if ({busy2, done2, rd_en2} !== 3'b000) begin nerr++; $display("FAIL reset_ctl2: got %b expected 000", {busy2, done2, rd_en2}); end
        nvec++; if (raddr2 !== 5'd0) begin nerr++; $display("FAIL reset_raddr2: got %0d expected 0", raddr2); end
        nvec++; if ({val2, vld2} !== 10'd0) begin nerr++; $display("FAIL reset_res2: got %h expected 0", {val2, vld2}); end
        nvec++; if ({busy4, done4, rd_en4, vld4, val4} !== 23'd0) begin nerr++; $display("FAIL reset_k4: got %h expected 0", {busy4, done4, rd_en4, vld4, val4}); end
`ifdef TOPK_INDEX_EN
        nvec++; if ({idx2, idx4} !== 30'd0) begin nerr++; $display("FAIL reset_idx: got %h expected 0", {idx2, idx4}); end
`endif
        reset = 1'b1;
        tick();
    endtask

    task automatic load_basic();
        clear_mems();
        mem2[0] = 4'd3; mem2[1] = 4'd9; mem2[2] = 4'd5;  mem2[3] = 4'd9;
        mem2[4] = 4'd1; mem2[5] = 4'd12; mem2[6] = 4'd7; mem2[7] = 4'd0;
    endtask

    task automatic test_basic();
        load_basic();
        scan(1'b0, 8, -1, -1, 1'b0, 16);
        nvec++; if (g_done_cyc != 10) begin nerr++; $display("FAIL basic_done_cyc: got %0d expected 10", g_done_cyc); end
        nvec++; if (g_ndone != 1) begin nerr++; $display("FAIL basic_ndone: got %0d expected 1", g_ndone); end
        nvec++; if (g_nrd != 8 || g_aerr != 0) begin nerr++; $display("FAIL basic_reads: got %0d reads %0d addr errs expected 8/0", g_nrd, g_aerr); end
        nvec++; if (g_bz_done !== 1'b0) begin nerr++; $display("FAIL basic_busy_at_done: got %b expected 0", g_bz_done); end
        nvec++; if (val2 !== 8'h9C) begin nerr++; $display("FAIL basic_val: got %h expected 9c", val2); end
        nvec++; if (vld2 !== 2'b11) begin nerr++; $display("FAIL basic_vld: got %b expected 11", vld2); end
`ifdef TOPK_INDEX_EN
        nvec++; if (idx2 !== {5'd1, 5'd5}) begin nerr++; $display("FAIL basic_idx: got %h expected %h", idx2, {5'd1, 5'd5}); end
`endif
    endtask

    task automatic test_mid_insert();
        clear_mems();
        mem2[0] = 4'd8; mem2[1] = 4'd2; mem2[2] = 4'd5;
        scan(1'b0, 3, -1, -1, 1'b0, 10);
        nvec++; if (g_done_cyc != 5) begin nerr++; $display("FAIL mid_done_cyc: got %0d expected 5", g_done_cyc); end
        nvec++; if (val2 !== 8'h58) begin nerr++; $display("FAIL mid_val: got %h expected 58", val2); end
        nvec++; if (vld2 !== 2'b11) begin nerr++; $display("FAIL mid_vld: got %b expected 11", vld2); end
    endtask

    task automatic test_len0();
        clear_mems();
        scan(1'b0, 0, -1, -1, 1'b0, 8);
        nvec++; if (g_done_cyc != 2) begin nerr++; $display("FAIL len0_done_cyc: got %0d expected 2", g_done_cyc); end
        nvec++; if (g_nrd != 0) begin nerr++; $display("FAIL len0_reads: got %0d expected 0", g_nrd); end
        nvec++; if ({val2, vld2} !== 10'd0) begin nerr++; $display("FAIL len0_res: got %h expected 0", {val2, vld2}); end
        scan(1'b0, 1, -1, -1, 1'b0, 8);
        nvec++; if (g_done_cyc != 3) begin nerr++; $display("FAIL len1_done_cyc: got %0d expected 3", g_done_cyc); end
        nvec++; if (vld2 !== 2'b01 || val2 !== 8'h00) begin nerr++; $display("FAIL len1_res: got vld %b val %h expected 01/00", vld2, val2); end
    endtask

    task automatic test_clamp();
        clear_mems();
        for (int i = 0; i < 32; i++) mem4[i] = 4'(i % 16);
        scan(1'b1, 40, -1, -1, 1'b0, 40);
        nvec++; if (g_nrd != 32) begin nerr++; $display("FAIL clamp_reads: got %0d expected 32", g_nrd); end
        nvec++; if (g_maxa != 31 || g_aerr != 0) begin nerr++; $display("FAIL clamp_addr: got max %0d errs %0d expected 31/0", g_maxa, g_aerr); end
        nvec++; if (g_done_cyc != 34) begin nerr++; $display("FAIL clamp_done_cyc: got %0d expected 34", g_done_cyc); end
        nvec++; if (val4 !== 16'hEEFF) begin nerr++; $display("FAIL clamp_val: got %h expected eeff", val4); end
        nvec++; if (vld4 !== 4'hF) begin nerr++; $display("FAIL clamp_vld: got %b expected 1111", vld4); end
`ifdef TOPK_INDEX_EN
        nvec++; if (idx4 !== {5'd30, 5'd14, 5'd31, 5'd15}) begin nerr++; $display("FAIL clamp_idx: got %h expected %h", idx4, {5'd30, 5'd14, 5'd31, 5'd15}); end
`endif
    endtask

    task automatic test_reset_mid();
        load_basic();
        scan(1'b0, 8, -1, 4, 1'b0, 20);
        nvec++; if (g_bz_rst !== 1'b0) begin nerr++; $display("FAIL rstmid_busy: got %b expected 0", g_bz_rst); end
        nvec++; if (g_vld_rst !== 4'h0) begin nerr++; $display("FAIL rstmid_vld: got %b expected 0", g_vld_rst); end
        nvec++; if (g_ndone != 0) begin nerr++; $display("FAIL rstmid_no_done: got %0d expected 0", g_ndone); end
        scan(1'b0, 8, -1, -1, 1'b0, 16);
        nvec++; if (g_done_cyc != 10 || val2 !== 8'h9C || vld2 !== 2'b11) begin nerr++; $display("FAIL rstmid_rerun: got cyc %0d val %h vld %b expected 10/9c/11", g_done_cyc, val2, vld2); end
    endtask

    task automatic test_back_to_back();
        load_basic();
        scan(1'b0, 8, 3, -1, 1'b1, 20);
        nvec++; if (g_ndone != 1 || g_done_cyc != 10) begin nerr++; $display("FAIL b2b_done: got %0d pulses at %0d expected 1 at 10", g_ndone, g_done_cyc); end
        nvec++; if (g_nrd != 8) begin nerr++; $display("FAIL b2b_reads: got %0d expected 8", g_nrd); end
        nvec++; if (g_bz_after !== 1'b0) begin nerr++; $display("FAIL b2b_start_in_done: got busy %b expected 0", g_bz_after); end
        nvec++; if (val2 !== 8'h9C || vld2 !== 2'b11) begin nerr++; $display("FAIL b2b_res: got val %h vld %b expected 9c/11", val2, vld2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_insert();
        test_len0();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
